// File: rtl/argmax_result_stage.sv
// Argmax over the final-layer output vector: scans one element per clock and reports
// the index of the largest one. Define ARGMAX_SIGNED_EN for two's-complement compares.
module argmax_result_stage #(
  parameter int NUM_INPUTS = 10,
  parameter int DATA_WIDTH = 16,
  parameter int IDX_WIDTH  = 32
) (
  input  logic                             s_axi_aclk,
  input  logic                             reset,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] i_data,
  input  logic                             i_valid,
  output logic                             i_ready,
  output logic [IDX_WIDTH-1:0]             o_data,
  output logic                             o_data_valid,
  output logic                             o_busy
);

  localparam int CW = $clog2(NUM_INPUTS) + 1;

  typedef logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] vec_t;
  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

  state_t                state_q, state_d;
  vec_t                  buf_q, buf_d;
  logic [DATA_WIDTH-1:0] max_q, max_d;
  logic [CW-1:0]         idx_q, idx_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IDX_WIDTH-1:0]  odata_q, odata_d;
  logic                  ovld_q, ovld_d;

  logic [DATA_WIDTH-1:0] cur_elem;
  logic                  cur_gt;
  logic [CW-1:0]         scan_idx;
  logic                  accept;

  function automatic logic elem_gt(input logic [DATA_WIDTH-1:0] a,
                                   input logic [DATA_WIDTH-1:0] b);
`ifdef ARGMAX_SIGNED_EN
    return $signed(a) > $signed(b);
`else
    return a > b;
`endif
  endfunction

  // Element select by counter value; written as a compare chain so the
  // counter may be wider than the index range without out-of-range reads.
  always_comb begin
    cur_elem = '0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      if (cnt_q == CW'(k)) cur_elem = buf_q[k];
    end
  end

  // Strict compare: equal elements never displace the earlier index.
  assign cur_gt   = elem_gt(cur_elem, max_q);
  assign scan_idx = cur_gt ? cnt_q : idx_q;

  assign i_ready = (state_q == IDLE) && !reset;
  assign accept  = i_valid && i_ready;

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    max_d   = max_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    odata_d = odata_q;
    ovld_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          buf_d = i_data;
          max_d = i_data[DATA_WIDTH-1:0];
          idx_d = '0;
          cnt_d = CW'(1);
          if (NUM_INPUTS == 1) begin
            // Single-element vector: the answer is trivially element 0.
            odata_d = '0;
            ovld_d  = 1'b1;
          end else begin
            state_d = SCAN;
          end
        end
      end
      SCAN: begin
        if (cur_gt) max_d = cur_elem;
        idx_d = scan_idx;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(NUM_INPUTS - 1)) begin
          odata_d = IDX_WIDTH'(scan_idx);
          ovld_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge s_axi_aclk) begin
    if (reset) begin
      state_q <= IDLE;
      buf_q   <= '0;
      max_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      odata_q <= '0;
      ovld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      max_q   <= max_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      odata_q <= odata_d;
      ovld_q  <= ovld_d;
    end
  end

  assign o_data       = odata_q;
  assign o_data_valid = ovld_q;
  assign o_busy       = (state_q == SCAN);

endmodule

// File: tb/tb_argmax_result_stage.sv
// Randomized and directed bench for argmax_result_stage (10-element and 1-element builds)
// against an array-search reference model.
module tb_argmax_result_stage;
  localparam int N  = 10;
  localparam int DW = 16;
  localparam int IW = 32;

  typedef logic [N-1:0][DW-1:0] vec_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [N*DW-1:0] i_data = '0;
  logic          i_valid = 1'b0;
  logic          i_ready, o_data_valid, o_busy;
  logic [IW-1:0] o_data;

  logic [DW-1:0] i_data1 = '0;
  logic          i_valid1 = 1'b0;
  logic          i_ready1, o_data_valid1, o_busy1;
  logic [IW-1:0] o_data1;

  int n_cmp = 0;
  int n_bad = 0;

  argmax_result_stage #(.NUM_INPUTS(N), .DATA_WIDTH(DW), .IDX_WIDTH(IW)) dut (
    .s_axi_aclk(clk), .reset(reset), .i_data(i_data), .i_valid(i_valid),
    .i_ready(i_ready), .o_data(o_data), .o_data_valid(o_data_valid), .o_busy(o_busy));

  argmax_result_stage #(.NUM_INPUTS(1), .DATA_WIDTH(DW), .IDX_WIDTH(IW)) dut1 (
    .s_axi_aclk(clk), .reset(reset), .i_data(i_data1), .i_valid(i_valid1),
    .i_ready(i_ready1), .o_data(o_data1), .o_data_valid(o_data_valid1), .o_busy(o_busy1));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference: first index holding the largest value.
  function automatic int ref_argmax(input vec_t v);
    int best = 0;
    for (int k = 1; k < N; k++) begin
`ifdef ARGMAX_SIGNED_EN
      if ($signed(v[k]) > $signed(v[best])) best = k;
`else
      if (v[k] > v[best]) best = k;
`endif
    end
    return best;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vector(input vec_t v, input int exp, input string name);
    int lat = 0;
    int guard = 0;
    while (!i_ready && guard < 40) begin step(); guard++; end
    i_data = v; i_valid = 1'b1;
    step();
    i_valid = 1'b0;
    n_cmp++; if (i_ready !== 1'b0) begin n_bad++; $display("FAIL %s ready_after_accept: got %b want 0", name, i_ready); end
    n_cmp++; if (o_busy !== 1'b1) begin n_bad++; $display("FAIL %s busy_after_accept: got %b want 1", name, o_busy); end
    while (!o_data_valid && lat < 30) begin step(); lat++; end
    n_cmp++; if (lat !== 9) begin n_bad++; $display("FAIL %s latency: got %0d want 9", name, lat); end
    n_cmp++; if (o_data !== IW'(exp)) begin n_bad++; $display("FAIL %s index: got %0d want %0d", name, o_data, exp); end
    n_cmp++; if (i_ready !== 1'b1) begin n_bad++; $display("FAIL %s ready_at_pulse: got %b want 1", name, i_ready); end
    n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL %s busy_at_pulse: got %b want 0", name, o_busy); end
    step();
    n_cmp++; if (o_data_valid !== 1'b0) begin n_bad++; $display("FAIL %s pulse_width: got %b want 0", name, o_data_valid); end
    n_cmp++; if (o_data !== IW'(exp)) begin n_bad++; $display("FAIL %s index_hold: got %0d want %0d", name, o_data, exp); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    n_cmp++; if (o_data !== '0) begin n_bad++; $display("FAIL reset_odata: got %0d want 0", o_data); end
    n_cmp++; if (o_data_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", o_data_valid); end
    n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", o_busy); end
    n_cmp++; if (i_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready_in_reset: got %b want 0", i_ready); end
    reset = 1'b0;
    #1;
    n_cmp++; if (i_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready_after: got %b want 1", i_ready); end
    n_cmp++; if (i_ready1 !== 1'b1) begin n_bad++; $display("FAIL reset_ready1_after: got %b want 1", i_ready1); end
    n_cmp++; if (o_data1 !== '0) begin n_bad++; $display("FAIL reset_odata1: got %0d want 0", o_data1); end
    step();
  endtask

  task automatic test_directed();
    vec_t v;
    v = '0; v[0] = 16'd3; v[1] = 16'd9; v[2] = 16'd1; v[9] = 16'd2;
    run_vector(v, 1, "basic");
    v = '0; v[0] = 16'd5; v[1] = 16'd7; v[2] = 16'd7; v[9] = 16'd7;
    run_vector(v, 1, "ties");
    v = '0;
    run_vector(v, 0, "all_zero");
    v = '0; v[9] = 16'h7FFF;
    run_vector(v, 9, "max_last");
    v = '0; v[4] = 16'hFFFF; v[6] = 16'h0001;
`ifdef ARGMAX_SIGNED_EN
    run_vector(v, 6, "ffff_signed");
`else
    run_vector(v, 4, "ffff_unsigned");
`endif
  endtask

  task automatic test_random();
    vec_t v;
    for (int it = 0; it < 25; it++) begin
      bit narrow = $urandom_range(0, 1) == 1;
      for (int k = 0; k < N; k++)
        v[k] = narrow ? DW'($urandom_range(0, 3)) : DW'($urandom);
      run_vector(v, ref_argmax(v), "random");
    end
  endtask

  task automatic test_back_to_back();
    vec_t v1, v2;
    int pulses = 0;
    int p1 = -1;
    int p2 = -1;
    v1 = '0; v1[3] = 16'd50; v1[8] = 16'd50;
    v2 = '0; v2[7] = 16'd90; v2[3] = 16'd20;
    i_data = v1; i_valid = 1'b1;
    step();
    i_valid = 1'b0;
    step(); step();
    i_data = v2; i_valid = 1'b1;
    for (int c = 3; c < 40; c++) begin
      step();
      if (pulses == 1 && c == p1 + 1) begin
        i_valid = 1'b0;
        n_cmp++; if (o_busy !== 1'b1) begin n_bad++; $display("FAIL b2b_second_accept: busy got %b want 1", o_busy); end
      end
      if (o_data_valid) begin
        pulses++;
        if (pulses == 1) begin
          p1 = c;
          n_cmp++; if (o_data !== IW'(3)) begin n_bad++; $display("FAIL b2b_first_index: got %0d want 3", o_data); end
        end else begin
          p2 = c;
          n_cmp++; if (o_data !== IW'(7)) begin n_bad++; $display("FAIL b2b_second_index: got %0d want 7", o_data); end
        end
      end else if (pulses == 1) begin
        n_cmp++; if (o_data !== IW'(3)) begin n_bad++; $display("FAIL b2b_hold: got %0d want 3", o_data); end
      end
    end
    i_valid = 1'b0;
    n_cmp++; if (pulses !== 2) begin n_bad++; $display("FAIL b2b_pulse_count: got %0d want 2", pulses); end
    n_cmp++; if (p1 !== 9) begin n_bad++; $display("FAIL b2b_first_latency: got %0d want 9", p1); end
    n_cmp++; if (p2 !== p1 + 10) begin n_bad++; $display("FAIL b2b_second_cycle: got %0d want %0d", p2, p1 + 10); end
  endtask

  task automatic test_reset_mid_scan();
    vec_t v;
    int pulses = 0;
    v = '0; v[5] = 16'd40;
    run_vector(v, 5, "pre_abort");
    v = '0; v[8] = 16'd77;
    i_data = v; i_valid = 1'b1;
    step();
    i_valid = 1'b0;
    repeat (4) step();
    reset = 1'b1;
    #1;
    n_cmp++; if (i_ready !== 1'b0) begin n_bad++; $display("FAIL abort_ready_in_reset: got %b want 0", i_ready); end
    step();
    reset = 1'b0;
    #1;
    n_cmp++; if (o_data !== '0) begin n_bad++; $display("FAIL abort_odata: got %0d want 0", o_data); end
    n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b want 0", o_busy); end
    n_cmp++; if (i_ready !== 1'b1) begin n_bad++; $display("FAIL abort_ready: got %b want 1", i_ready); end
    for (int c = 0; c < 20; c++) begin
      if (o_data_valid) pulses++;
      step();
    end
    n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL abort_no_pulse: got %0d pulses want 0", pulses); end
    n_cmp++; if (o_data !== '0) begin n_bad++; $display("FAIL abort_odata_hold: got %0d want 0", o_data); end
    v = '0; v[2] = 16'd8;
    run_vector(v, 2, "after_abort");
  endtask

  task automatic test_single();
    i_data1 = 16'h0042; i_valid1 = 1'b1;
    step();
    i_valid1 = 1'b0;
    n_cmp++; if (o_data_valid1 !== 1'b1) begin n_bad++; $display("FAIL single_pulse: got %b want 1", o_data_valid1); end
    n_cmp++; if (o_data1 !== '0) begin n_bad++; $display("FAIL single_index: got %0d want 0", o_data1); end
    n_cmp++; if (i_ready1 !== 1'b1) begin n_bad++; $display("FAIL single_ready: got %b want 1", i_ready1); end
    n_cmp++; if (o_busy1 !== 1'b0) begin n_bad++; $display("FAIL single_busy: got %b want 0", o_busy1); end
    step();
    n_cmp++; if (o_data_valid1 !== 1'b0) begin n_bad++; $display("FAIL single_pulse_width: got %b want 0", o_data_valid1); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid_scan();
    test_single();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
